// File: rtl/clk_ratio_monitor.sv
// ---------------------------------------------------------------------------
// clk_ratio_monitor
//
// Purpose:
//   Oversamples a slower clock (mon_in) with the faster sampling clock (clk)
//   and measures the width of each high and low phase in clk cycles. Every
//   completed period (rise to rise) is compared against the expected high and
//   low widths. Bad periods and stuck inputs (no edge for TIMEOUT cycles)
//   are counted, and locked is raised after LOCK_CNT consecutive good
//   periods.
//
// Ports:
//   clk          sampling clock
//   rst          asynchronous active-high reset
//   mon_in       monitored clock, asynchronous to clk
//   enable       monitoring enable; low holds the FSM in IDLE
//   clear_err    synchronous clear of err_count and stuck
//   high_width   last measured high-phase width (clk cycles)
//   low_width    last measured low-phase width (clk cycles)
//   width_valid  one-cycle pulse when a full period completes
//   err_pulse    one-cycle pulse on a bad period or a timeout
//   err_count    saturating count of error events
//   locked       LOCK_CNT consecutive good periods seen
//   stuck        sticky flag, set on timeout
// ---------------------------------------------------------------------------
module clk_ratio_monitor #(
  parameter int CNT_W    = 8,
  parameter int EXP_HIGH = 4,
  parameter int EXP_LOW  = 4,
  parameter int TOL      = 0,
  parameter int LOCK_CNT = 4,
  parameter int TIMEOUT  = 64,
  parameter int ERR_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mon_in,
  input  logic             enable,
  input  logic             clear_err,
  output logic [CNT_W-1:0] high_width,
  output logic [CNT_W-1:0] low_width,
  output logic             width_valid,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count,
  output logic             locked,
  output logic             stuck
);

  // Good-period counter only needs to reach LOCK_CNT.
  localparam int GOOD_W = (LOCK_CNT < 2) ? 1 : $clog2(LOCK_CNT + 1);

  localparam logic [CNT_W-1:0]  EXP_HIGH_C = CNT_W'(EXP_HIGH);
  localparam logic [CNT_W-1:0]  EXP_LOW_C  = CNT_W'(EXP_LOW);
  localparam logic [CNT_W-1:0]  TOL_C      = CNT_W'(TOL);
  localparam logic [CNT_W-1:0]  TIMEOUT_C  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
  localparam logic [GOOD_W-1:0] LOCK_C     = GOOD_W'(LOCK_CNT);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ACQUIRE   = 2'd1,
    MEAS_HIGH = 2'd2,
    MEAS_LOW  = 2'd3
  } state_t;

  // Synchronizer and edge history
  logic s1_q, s1_d;
  logic s2_q, s2_d;
  logic s3_q, s3_d;

  // Measurement state
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] high_width_q, high_width_d;
  logic [CNT_W-1:0] low_width_q, low_width_d;

  // Status
  logic              width_valid_q, width_valid_d;
  logic              err_pulse_q, err_pulse_d;
  logic [ERR_W-1:0]  err_count_q, err_count_d;
  logic              locked_q, locked_d;
  logic              stuck_q, stuck_d;
  logic [GOOD_W-1:0] good_q, good_d;

  // Derived events
  logic             rise;
  logic             fall;
  logic             in_meas;
  logic             timeout_hit;
  logic             period_done;
  logic             period_good;
  logic             err_event;
  logic [CNT_W-1:0] cnt_inc;
  logic [ERR_W-1:0] err_base;

  // Absolute difference of two unsigned values, computed without wrap.
  function automatic logic [CNT_W-1:0] abs_diff(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  // Two-flop synchronizer followed by one history flop for edge detection.
  // The same fixed latency applies to rising and falling edges, so the
  // measured widths are not biased by it.
  always_comb begin
    s1_d = mon_in;
    s2_d = s1_q;
    s3_d = s2_q;
  end

  assign rise    = s2_q & ~s3_q;
  assign fall    = ~s2_q & s3_q;
  assign in_meas = (state_q == MEAS_HIGH) || (state_q == MEAS_LOW);
  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_ONE;

  // A timeout pre-empts any edge seen in the same cycle. A completed
  // period is the rise that ends a low phase; at that moment cnt_q holds
  // the low width and high_width_q the high width of the same period.
  assign timeout_hit = enable && in_meas && (cnt_q == TIMEOUT_C);
  assign period_done = enable && (state_q == MEAS_LOW) && !timeout_hit && rise;
  assign period_good = (abs_diff(high_width_q, EXP_HIGH_C) <= TOL_C) &&
                       (abs_diff(cnt_q, EXP_LOW_C) <= TOL_C);
  assign err_event   = timeout_hit || (period_done && !period_good);

  // Next-state logic of the measurement FSM. Dropping enable wins over
  // everything; a timeout sends the FSM back to wait for a fresh rise.
  // The phase counter starts at 1 on the edge cycle, so at the next edge
  // it holds exactly the number of cycles the phase lasted.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    high_width_d = high_width_q;
    low_width_d  = low_width_q;

    if (!enable) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (timeout_hit) begin
      state_d = ACQUIRE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = ACQUIRE;
          cnt_d   = '0;
        end
        ACQUIRE: begin
          if (rise) begin
            state_d = MEAS_HIGH;
            cnt_d   = CNT_ONE;
          end
        end
        MEAS_HIGH: begin
          if (fall) begin
            high_width_d = cnt_q;
            cnt_d        = CNT_ONE;
            state_d      = MEAS_LOW;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        MEAS_LOW: begin
          if (rise) begin
            low_width_d = cnt_q;
            cnt_d       = CNT_ONE;
            state_d     = MEAS_HIGH;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Error and lock bookkeeping. clear_err is applied first so an error in
  // the same cycle still counts as one and can set stuck again.
  always_comb begin
    width_valid_d = period_done;
    err_pulse_d   = err_event;

    err_base    = clear_err ? '0 : err_count_q;
    err_count_d = err_base;
    if (err_event && (err_base != '1)) begin
      err_count_d = err_base + ERR_W'(1);
    end

    if (timeout_hit) begin
      stuck_d = 1'b1;
    end else if (clear_err) begin
      stuck_d = 1'b0;
    end else begin
      stuck_d = stuck_q;
    end

    good_d   = good_q;
    locked_d = locked_q;
    if (!enable || err_event) begin
      good_d   = '0;
      locked_d = 1'b0;
    end else if (period_done) begin
      if (good_q != LOCK_C) begin
        good_d = good_q + GOOD_W'(1);
      end
      locked_d = (good_d == LOCK_C);
    end
  end

  // All state registers share the asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q          <= 1'b0;
      s2_q          <= 1'b0;
      s3_q          <= 1'b0;
      state_q       <= IDLE;
      cnt_q         <= '0;
      high_width_q  <= '0;
      low_width_q   <= '0;
      width_valid_q <= 1'b0;
      err_pulse_q   <= 1'b0;
      err_count_q   <= '0;
      locked_q      <= 1'b0;
      stuck_q       <= 1'b0;
      good_q        <= '0;
    end else begin
      s1_q          <= s1_d;
      s2_q          <= s2_d;
      s3_q          <= s3_d;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      high_width_q  <= high_width_d;
      low_width_q   <= low_width_d;
      width_valid_q <= width_valid_d;
      err_pulse_q   <= err_pulse_d;
      err_count_q   <= err_count_d;
      locked_q      <= locked_d;
      stuck_q       <= stuck_d;
      good_q        <= good_d;
    end
  end

  assign high_width  = high_width_q;
  assign low_width   = low_width_q;
  assign width_valid = width_valid_q;
  assign err_pulse   = err_pulse_q;
  assign err_count   = err_count_q;
  assign locked      = locked_q;
  assign stuck       = stuck_q;

endmodule

// File: tb/tb_clk_ratio_monitor.sv
// ---------------------------------------------------------------------------
// tb_clk_ratio_monitor
//
// Drives directed mon_in waveforms into two monitors (TOL=0 and TOL=1) and
// compares the TOL=0 instance every cycle against a timestamp-based model
// of the phase measurement, error and lock rules. Hand-computed literal
// expectations at the end of each scenario pin both DUT and model.
// ---------------------------------------------------------------------------
module tb_clk_ratio_monitor;

  localparam int CNT_W    = 8;
  localparam int EXP_HIGH = 4;
  localparam int EXP_LOW  = 4;
  localparam int TOL      = 0;
  localparam int LOCK_CNT = 4;
  localparam int TIMEOUT  = 64;
  localparam int ERR_W    = 16;
  localparam int ERR_MAX  = (1 << ERR_W) - 1;

  logic clk       = 1'b0;
  logic rst       = 1'b1;
  logic mon_in    = 1'b0;
  logic enable    = 1'b0;
  logic clear_err = 1'b0;

  logic [CNT_W-1:0] high_width, low_width;
  logic             width_valid, err_pulse, locked, stuck;
  logic [ERR_W-1:0] err_count;

  logic [CNT_W-1:0] t_high_width, t_low_width;
  logic             t_width_valid, t_err_pulse, t_locked, t_stuck;
  logic [ERR_W-1:0] t_err_count;

  int checks   = 0;
  int failures = 0;

  int valid_seen   = 0;
  int t_valid_seen = 0;
  int t_err_seen   = 0;
  int v0           = 0;

  clk_ratio_monitor #(
    .CNT_W(CNT_W), .EXP_HIGH(EXP_HIGH), .EXP_LOW(EXP_LOW), .TOL(TOL),
    .LOCK_CNT(LOCK_CNT), .TIMEOUT(TIMEOUT), .ERR_W(ERR_W)
  ) dut (
    .clk(clk), .rst(rst), .mon_in(mon_in), .enable(enable),
    .clear_err(clear_err), .high_width(high_width), .low_width(low_width),
    .width_valid(width_valid), .err_pulse(err_pulse), .err_count(err_count),
    .locked(locked), .stuck(stuck)
  );

  clk_ratio_monitor #(
    .CNT_W(CNT_W), .EXP_HIGH(EXP_HIGH), .EXP_LOW(EXP_LOW), .TOL(1),
    .LOCK_CNT(LOCK_CNT), .TIMEOUT(TIMEOUT), .ERR_W(ERR_W)
  ) dut_tol (
    .clk(clk), .rst(rst), .mon_in(mon_in), .enable(enable),
    .clear_err(clear_err), .high_width(t_high_width), .low_width(t_low_width),
    .width_valid(t_width_valid), .err_pulse(t_err_pulse),
    .err_count(t_err_count), .locked(t_locked), .stuck(t_stuck)
  );

  always #5 clk = ~clk;

  // Single comparison point: counts the check and reports any difference.
  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Advance n clock edges, then settle 2 time units past the edge where
  // inputs are changed.
  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // One mon_in period: hi cycles high followed by lo cycles low.
  task automatic applyStimulus(input int hi, input int lo);
    mon_in = 1'b1;
    waitCycles(hi);
    mon_in = 1'b0;
    waitCycles(lo);
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // -------------------------------------------------------------------------
  // Behavioural model. mon_in is seen two samples late (synchronizer); a
  // phase width is the number of clk edges between the edges that bound it,
  // tracked as timestamps. Lock is "at least LOCK_CNT good periods in a row".
  // -------------------------------------------------------------------------
  typedef enum int {P_OFF, P_ARMED, P_HIGH, P_LOW} phase_t;
  phase_t phase = P_OFF;
  int  n      = 0;
  int  start  = 0;
  int  run    = 0;
  int  m_hw   = 0;
  int  m_lw   = 0;
  int  m_errc = 0;
  int  base   = 0;
  bit  m_valid = 1'b0, m_err = 1'b0, m_locked = 1'b0, m_stuck = 1'b0;
  bit  h0 = 1'b0, h1 = 1'b0, h2 = 1'b0;
  bit  rise_ev, fall_ev, tmo, done, ok;

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      phase = P_OFF; n = 0; start = 0; run = 0;
      m_hw = 0; m_lw = 0; m_errc = 0;
      m_valid = 0; m_err = 0; m_locked = 0; m_stuck = 0;
      h0 = 0; h1 = 0; h2 = 0;
    end else begin
      rise_ev = h1 && !h2;
      fall_ev = !h1 && h2;
      h2 = h1; h1 = h0; h0 = mon_in;
      n++;
      m_valid = 0; m_err = 0; tmo = 0; done = 0; ok = 0;
      base = clear_err ? 0 : m_errc;
      if (clear_err) m_stuck = 0;

      if (!enable) begin
        phase = P_OFF; run = 0; m_locked = 0;
      end else begin
        case (phase)
          P_OFF:   phase = P_ARMED;
          P_ARMED: if (rise_ev) begin phase = P_HIGH; start = n; end
          P_HIGH: begin
            if (n - start == TIMEOUT) tmo = 1;
            else if (fall_ev) begin m_hw = n - start; start = n; phase = P_LOW; end
          end
          P_LOW: begin
            if (n - start == TIMEOUT) tmo = 1;
            else if (rise_ev) begin
              m_lw = n - start; start = n; phase = P_HIGH; done = 1;
              ok = (iabs(m_hw - EXP_HIGH) <= TOL) && (iabs(m_lw - EXP_LOW) <= TOL);
            end
          end
          default: phase = P_OFF;
        endcase
      end

      if (tmo) begin
        phase = P_ARMED; m_err = 1; m_stuck = 1; run = 0; m_locked = 0;
      end else if (done) begin
        m_valid = 1;
        if (ok) begin
          run++;
          m_locked = (run >= LOCK_CNT);
        end else begin
          m_err = 1; run = 0; m_locked = 0;
        end
      end
      m_errc = m_err ? ((base + 1 > ERR_MAX) ? ERR_MAX : base + 1) : base;
    end
  end

  // Cycle-by-cycle comparison on the falling edge, away from the sampling edge.
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      checkOutput("high_width",  int'(high_width),  m_hw);
      checkOutput("low_width",   int'(low_width),   m_lw);
      checkOutput("width_valid", int'(width_valid), int'(m_valid));
      checkOutput("err_pulse",   int'(err_pulse),   int'(m_err));
      checkOutput("err_count",   int'(err_count),   m_errc);
      checkOutput("locked",      int'(locked),      int'(m_locked));
      checkOutput("stuck",       int'(stuck),       int'(m_stuck));
      if (width_valid) valid_seen++;
      if (t_width_valid) t_valid_seen++;
      if (t_err_pulse) t_err_seen++;
    end else begin
      t_valid_seen = 0;
      t_err_seen   = 0;
    end
  end

  initial begin
    // Reset, then enable with mon_in idle low
    repeat (2) @(posedge clk);
    #2;
    checkOutput("reset_locked", int'(locked), 0);
    checkOutput("reset_err_count", int'(err_count), 0);
    rst    = 1'b0;
    enable = 1'b1;
    waitCycles(4);

    // Nominal 4/4 clock: lock on the 4th completed period
    for (int i = 0; i < 4; i++) applyStimulus(4, 4);
    checkOutput("lock_after_3_periods", int'(locked), 0);
    applyStimulus(4, 4);
    checkOutput("lock_after_4_periods", int'(locked), 1);
    applyStimulus(4, 4);
    applyStimulus(4, 4);
    checkOutput("nominal_high_width", int'(high_width), 4);
    checkOutput("nominal_low_width", int'(low_width), 4);
    checkOutput("nominal_err_count", int'(err_count), 0);

    // One stretched high phase, then recovery
    applyStimulus(6, 4);
    applyStimulus(4, 4);
    checkOutput("stretch_err_count", int'(err_count), 1);
    checkOutput("stretch_locked", int'(locked), 0);
    checkOutput("stretch_high_width", int'(high_width), 4);
    for (int i = 0; i < 3; i++) applyStimulus(4, 4);
    checkOutput("relock_3_good", int'(locked), 0);
    applyStimulus(4, 4);
    checkOutput("relock_4_good", int'(locked), 1);

    // mon_in stuck high long enough to time out
    mon_in = 1'b1;
    waitCycles(70);
    mon_in = 1'b0;
    waitCycles(4);
    checkOutput("timeout_stuck", int'(stuck), 1);
    checkOutput("timeout_err_count", int'(err_count), 2);
    checkOutput("timeout_locked", int'(locked), 0);
    for (int i = 0; i < 5; i++) applyStimulus(4, 4);
    checkOutput("post_timeout_locked", int'(locked), 1);
    checkOutput("post_timeout_stuck_sticky", int'(stuck), 1);

    // clear_err on the very edge that completes a bad period
    applyStimulus(6, 4);
    mon_in = 1'b1;
    waitCycles(2);
    clear_err = 1'b1;
    waitCycles(1);
    clear_err = 1'b0;
    waitCycles(1);
    mon_in = 1'b0;
    waitCycles(4);
    checkOutput("clear_vs_error_count", int'(err_count), 1);
    checkOutput("clear_vs_error_stuck", int'(stuck), 0);

    // Drop enable in the middle of a high phase
    for (int i = 0; i < 5; i++) applyStimulus(4, 4);
    checkOutput("pre_disable_locked", int'(locked), 1);
    mon_in = 1'b1;
    waitCycles(4);
    v0     = valid_seen;
    enable = 1'b0;
    waitCycles(1);
    checkOutput("disable_locked", int'(locked), 0);
    waitCycles(3);
    mon_in = 1'b0;
    waitCycles(4);
    checkOutput("disable_holds_width", int'(high_width), 4);
    enable = 1'b1;
    waitCycles(4);
    applyStimulus(4, 4);
    checkOutput("reenable_no_valid_yet", valid_seen - v0, 0);
    applyStimulus(4, 4);
    checkOutput("reenable_first_valid", valid_seen - v0, 1);

    // Async reset between clock edges in the middle of a measurement
    for (int i = 0; i < 4; i++) applyStimulus(4, 4);
    checkOutput("pre_reset_locked", int'(locked), 1);
    checkOutput("pre_reset_err_count", int'(err_count), 1);
    mon_in = 1'b1;
    waitCycles(4);
    #1;
    rst    = 1'b1;
    mon_in = 1'b0;
    #1;
    checkOutput("async_rst_locked", int'(locked), 0);
    checkOutput("async_rst_err_count", int'(err_count), 0);
    checkOutput("async_rst_high_width", int'(high_width), 0);
    checkOutput("async_rst_low_width", int'(low_width), 0);
    checkOutput("async_rst_tol_err_count", int'(t_err_count), 0);
    #5;
    rst = 1'b0;
    @(posedge clk);
    #2;
    waitCycles(3);

    // 5/3 periods: bad for TOL=0, good for TOL=1
    for (int i = 0; i < 6; i++) applyStimulus(5, 3);
    checkOutput("tol0_err_count", int'(err_count), 5);
    checkOutput("tol0_high_width", int'(high_width), 5);
    checkOutput("tol0_low_width", int'(low_width), 3);
    checkOutput("tol1_err_count", int'(t_err_count), 0);
    checkOutput("tol1_locked", int'(t_locked), 1);
    checkOutput("tol1_high_width", int'(t_high_width), 5);
    checkOutput("tol1_low_width", int'(t_low_width), 3);
    checkOutput("tol1_valid_count", t_valid_seen, 5);
    checkOutput("tol1_err_pulses", t_err_seen, 0);
    checkOutput("tol1_stuck", int'(t_stuck), 0);

    waitCycles(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/clk_ratio_monitor.md
Name: clk_ratio_monitor

Overview:
- Synchronous monitor that oversamples a slower testbench clock (e.g. clk_50) as a data signal, using a faster clock (e.g. clk_400).
- Measures high and low phase widths in sampling-clock cycles and checks them against expected values.
- Counts errors and asserts lock after a run of consecutive good periods.
- Sits in the testbench/verification layer and checks clocks produced by the clock generator.

Parameters:
- CNT_W, 8, width of phase counters and reported widths
- EXP_HIGH, 4, expected high-phase width in clk cycles
- EXP_LOW, 4, expected low-phase width in clk cycles
- TOL, 0, allowed absolute deviation per phase, in cycles
- LOCK_CNT, 4, consecutive good periods required to assert locked (must be ≥1)
- TIMEOUT, 64, cycles without an edge before a stuck error (must be < 2^CNT_W)
- ERR_W, 16, error counter width

Ports:
- clk  in  1  sampling clock
- rst  in  1  asynchronous active-high reset
- mon_in  in  1  monitored clock; asynchronous to clk
- enable  in  1  monitoring enable; when low, FSM held in IDLE
- clear_err  in  1  synchronous clear of err_count and stuck
- high_width  out  CNT_W  last measured high-phase width
- low_width  out  CNT_W  last measured low-phase width
- width_valid  out  1  one-cycle pulse when a full period (high+low) completes
- err_pulse  out  1  one-cycle pulse on an out-of-tolerance period or timeout
- err_count  out  ERR_W  saturating error count
- locked  out  1  LOCK_CNT consecutive good periods seen
- stuck  out  1  sticky; set on timeout

Behaviour:
- Reset: all outputs 0; sync flops 0; FSM in IDLE; counters 0.
- Input path:
  - mon_in passes through a 2-flop synchronizer (s2), then one history flop (s3).
  - rise = s2 & ~s3; fall = ~s2 & s3.
  - Latency from a mon_in edge to the detect strobe is 2–3 clk cycles. The latency does not bias measured widths.
- FSM states:
  - IDLE: entered on enable=0. locked and good count cleared; width outputs hold.
  - ACQUIRE: wait for rise; an initial partial phase is ignored.
  - MEAS_HIGH: on entry (rise cycle), phase counter = 1. Each following cycle with no fall, counter += 1, saturating at all ones. On fall: high_width ← counter, counter ← 1, go to MEAS_LOW.
  - MEAS_LOW: same counting. On rise: low_width ← counter, width_valid=1 in the next cycle, counter ← 1, go to MEAS_HIGH.
- Transitions:
  - IDLE→ACQUIRE when enable=1.
  - Any state→IDLE when enable=0; this takes priority over all other events.
- Period check (on width_valid):
  - Good when |high_width−EXP_HIGH| ≤ TOL and |low_width−EXP_LOW| ≤ TOL. Compare unsigned, without wrap.
  - Good period: good count += 1, saturating at LOCK_CNT. locked=1 once the count reaches LOCK_CNT.
  - Bad period: err_pulse=1, err_count += 1 (saturating at all ones), good count ← 0, locked ← 0.
- Timeout:
  - Triggered when the counter reaches TIMEOUT in MEAS_HIGH or MEAS_LOW.
  - Sets err_pulse=1, err_count += 1, stuck ← 1, locked ← 0, good count ← 0. FSM goes to ACQUIRE.
  - ACQUIRE itself never times out.
- clear_err:
  - Zeroes err_count and stuck.
  - If an error event happens in the same cycle, err_count = 1 and stuck reflects the event; the event wins over the clear.
- Async rst mid-measurement: immediate return to reset values. First period after reset is measured only after a fresh rise.

Test Plan:
- enable=1; mon_in toggles every 4 clk cycles (8-cycle period) for 6 periods → each width_valid shows high_width=4, low_width=4; locked rises at the 4th completed period; err_count=0.
- After lock, stretch one high phase to 6 cycles (TOL=0) → err_pulse once, err_count=1, locked=0. Resumes after 4 more good 4/4 periods.
- Hold mon_in high for 70 cycles → err_pulse at counter=64, stuck=1, err_count increments by 1. Resume toggling → relock after 4 good periods; stuck stays 1 until clear_err.
- Assert clear_err in the same cycle as a bad period → err_count=1 afterwards, not 0.
- Drop enable mid-high-phase → locked=0 next cycle; the partial period never produces width_valid. Re-enable → first width_valid only after a full rise-to-rise period.
- Assert rst asynchronously between clk edges mid-period → all outputs 0 immediately; TOL=1 with 5/3 widths → good, no error.
